// File: rtl/billiard_pkg.sv
// billiard_pkg: shared types, FSM states and edge-bit indices for ball kinematics
package billiard_pkg;
    typedef logic signed [10:0] speed_t;
    typedef logic signed [31:0] pos_fp_t;
    typedef enum logic [1:0] {IDLE, AIM, ROLL} ball_state_e;
    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;
    localparam int SPEED_MAX   = 1023;
    function automatic speed_t clamp_int(input int v, input int lim);
        return speed_t'((v > lim) ? lim : (v < -lim) ? -lim : v);
    endfunction
endpackage

// File: rtl/axis_integrator.sv
// axis_integrator: one-axis fixed-point position, speed, friction, saturation and edge reflection
module axis_integrator
    import billiard_pkg::*;
#(
    parameter int FRAC_BITS      = 6,
    parameter int INIT           = 0,
    parameter int FRICTION_SHIFT = 4,
    parameter int MIN_SPEED      = 2
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                respawn,
    input  logic                frame,
    input  logic                load,
    input  speed_t              load_speed,
    input  logic                hit_neg,
    input  logic                hit_pos,
    output logic signed [10:0]  pos_px,
    output speed_t              speed,
    output speed_t              speed_nxt
);
    localparam pos_fp_t SPAWN = pos_fp_t'(INIT * (2 ** FRAC_BITS));
    pos_fp_t pos;
    speed_t  mag, dec, rem, fric;
    logic    reflect;
    always_comb begin
        mag       = speed[10] ? -speed : speed;
        dec       = (mag >> FRICTION_SHIFT) + 11'sd1;
        rem       = mag - dec;
        fric      = (mag <= speed_t'(MIN_SPEED) || rem[10] || rem == '0) ? '0 : (speed[10] ? -rem : rem);
        reflect   = (hit_neg && speed[10]) || (hit_pos && !speed[10] && speed != '0);
        speed_nxt = load ? clamp_int(int'(load_speed), SPEED_MAX) : reflect ? -speed : frame ? fric : speed;
    end
    // position always integrates the pre-update speed, even when speed is reloaded or reflected
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            pos   <= SPAWN;
            speed <= '0;
        end else if (respawn) begin
            pos   <= SPAWN;
            speed <= '0;
        end else begin
            if (frame)
                pos <= pos + pos_fp_t'(speed);
            speed <= speed_nxt;
        end
    assign pos_px = 11'(pos >>> FRAC_BITS);
endmodule

// File: rtl/ball_kinematics.sv
// ball_kinematics: per-ball shot charging, motion FSM and two-axis integration
// Optional macro BALL_IMPULSE_EN enables velocity impulses from the collision resolver.
module ball_kinematics
    import billiard_pkg::*;
#(
    parameter int FRAC_BITS      = 6,
    parameter int INIT_X         = 100,
    parameter int INIT_Y         = 220,
    parameter int SPEED_STEP     = 200,
    parameter int MAX_SHOT_SPEED = 900,
    parameter int FRICTION_SHIFT = 4,
    parameter int MIN_SPEED      = 2
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               chargeUp,
    input  logic               chargeDown,
    input  logic               chargeLeft,
    input  logic               chargeRight,
    input  logic               releaseBall,
    input  logic               collision,
    input  logic [3:0]         HitEdgeCode,
    input  logic               respawn,
    input  logic               impulseValid,
    input  logic signed [10:0] impulseXspeed,
    input  logic signed [10:0] impulseYspeed,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic signed [10:0] XspeedOUT,
    output logic signed [10:0] YspeedOUT,
    output logic               moving,
    output logic               stoppedPulse
);
    ball_state_e state, state_nxt;
    speed_t      x_shot, y_shot, x_shot_nxt, y_shot_nxt, x_load, y_load, x_nxt, y_nxt;
    logic        imp, busy, rel, load, nz_load, stop_nxt;
`ifdef BALL_IMPULSE_EN
    assign imp    = impulseValid;
    assign x_load = imp ? impulseXspeed : x_shot;
    assign y_load = imp ? impulseYspeed : y_shot;
`else
    logic unused_impulse;
    assign unused_impulse = ^{impulseValid, impulseXspeed, impulseYspeed};
    assign imp    = 1'b0;
    assign x_load = x_shot;
    assign y_load = y_shot;
`endif
    // any higher-priority event in a cycle blocks charging and release
    always_comb begin
        busy       = respawn || imp || collision || startOfFrame;
        rel        = !busy && state == AIM && releaseBall;
        nz_load    = x_load != '0 || y_load != '0;
        load       = imp || (rel && nz_load);
        x_shot_nxt = clamp_int(int'(x_shot) + (chargeRight ? SPEED_STEP : 0) - (chargeLeft ? SPEED_STEP : 0), MAX_SHOT_SPEED);
        y_shot_nxt = clamp_int(int'(y_shot) + (chargeDown ? SPEED_STEP : 0) - (chargeUp ? SPEED_STEP : 0), MAX_SHOT_SPEED);
        state_nxt  = state;
        stop_nxt   = 1'b0;
        if (respawn)
            state_nxt = IDLE;
        else if (imp || rel)
            state_nxt = nz_load ? ROLL : IDLE;
        else if (state == ROLL && startOfFrame && x_nxt == '0 && y_nxt == '0) begin
            state_nxt = IDLE;
            stop_nxt  = 1'b1;
        end else if (!busy && state == IDLE && (chargeUp || chargeDown || chargeLeft || chargeRight))
            state_nxt = AIM;
    end
    always_ff @(posedge clk or negedge resetN)
        if (!resetN) begin
            state        <= IDLE;
            stoppedPulse <= 1'b0;
            x_shot       <= '0;
            y_shot       <= '0;
        end else begin
            state        <= state_nxt;
            stoppedPulse <= stop_nxt;
            if (respawn || rel) begin
                x_shot <= '0;
                y_shot <= '0;
            end else if (!busy && state != ROLL) begin
                x_shot <= x_shot_nxt;
                y_shot <= y_shot_nxt;
            end
        end
    axis_integrator #(.FRAC_BITS(FRAC_BITS), .INIT(INIT_X), .FRICTION_SHIFT(FRICTION_SHIFT), .MIN_SPEED(MIN_SPEED)) u_x (
        .clk(clk), .resetN(resetN), .respawn(respawn), .frame(startOfFrame), .load(load), .load_speed(x_load),
        .hit_neg(collision && HitEdgeCode[EDGE_LEFT]), .hit_pos(collision && HitEdgeCode[EDGE_RIGHT]),
        .pos_px(topLeftX), .speed(XspeedOUT), .speed_nxt(x_nxt)
    );
    axis_integrator #(.FRAC_BITS(FRAC_BITS), .INIT(INIT_Y), .FRICTION_SHIFT(FRICTION_SHIFT), .MIN_SPEED(MIN_SPEED)) u_y (
        .clk(clk), .resetN(resetN), .respawn(respawn), .frame(startOfFrame), .load(load), .load_speed(y_load),
        .hit_neg(collision && HitEdgeCode[EDGE_TOP]), .hit_pos(collision && HitEdgeCode[EDGE_BOTTOM]),
        .pos_px(topLeftY), .speed(YspeedOUT), .speed_nxt(y_nxt)
    );
    assign moving = state == ROLL;
endmodule

// File: tb/tb_ball_kinematics.sv
// tb_ball_kinematics: randomized and directed checks of ball_kinematics against a behavioural model
module tb_ball_kinematics;
    localparam logic [7:0] SOF = 8'h80, CU = 8'h40, CD = 8'h20, CL = 8'h10, CR = 8'h08, REL = 8'h04, COL = 8'h02, RSP = 8'h01;
    logic clk = 1'b0, resetN = 1'b0;
    logic startOfFrame = 0, chargeUp = 0, chargeDown = 0, chargeLeft = 0, chargeRight = 0;
    logic releaseBall = 0, collision = 0, respawn = 0, impulseValid = 0;
    logic [3:0] HitEdgeCode = '0;
    logic signed [10:0] impulseXspeed = '0, impulseYspeed = '0;
    logic signed [10:0] topLeftX, topLeftY, XspeedOUT, YspeedOUT;
    logic moving, stoppedPulse;
    int errors = 0, checks = 0;

    ball_kinematics dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .chargeUp(chargeUp), .chargeDown(chargeDown),
        .chargeLeft(chargeLeft), .chargeRight(chargeRight), .releaseBall(releaseBall), .collision(collision),
        .HitEdgeCode(HitEdgeCode), .respawn(respawn), .impulseValid(impulseValid), .impulseXspeed(impulseXspeed),
        .impulseYspeed(impulseYspeed), .topLeftX(topLeftX), .topLeftY(topLeftY), .XspeedOUT(XspeedOUT),
        .YspeedOUT(YspeedOUT), .moving(moving), .stoppedPulse(stoppedPulse)
    );

    always #5 clk = ~clk;

    // model state: positions in 1/64 px, speeds and shots as plain integers, st 0=idle 1=aim 2=roll
    typedef struct {int px; int py; int vx; int vy; int sx; int sy; int st; logic stp;} model_t;
    model_t m;

    function automatic model_t mreset();
        model_t r;
        r.px = 100 * 64; r.py = 220 * 64; r.vx = 0; r.vy = 0; r.sx = 0; r.sy = 0; r.st = 0; r.stp = 1'b0;
        return r;
    endfunction

    function automatic int clampi(int v, int l);
        return v > l ? l : v < -l ? -l : v;
    endfunction

    function automatic int fric(int v);
        int mg, r;
        mg = v < 0 ? -v : v;
        r = mg - (mg / 16 + 1);
        if (mg <= 2 || r <= 0) return 0;
        return v < 0 ? -r : r;
    endfunction

    function automatic int px_of(int p);
        logic signed [10:0] t;
        t = 11'(p >>> 6);
        return int'(t);
    endfunction

    function automatic model_t step(model_t c);
        model_t n;
        int nvx, nvy;
        logic imp;
        n = c;
        n.stp = 1'b0;
        if (respawn) return mreset();
        imp = 1'b0;
`ifdef BALL_IMPULSE_EN
        imp = impulseValid;
`endif
        if (startOfFrame) begin
            n.px = c.px + c.vx;
            n.py = c.py + c.vy;
        end
        if (imp) begin
            n.vx = clampi(int'(impulseXspeed), 1023);
            n.vy = clampi(int'(impulseYspeed), 1023);
            n.st = (n.vx != 0 || n.vy != 0) ? 2 : 0;
            return n;
        end
        nvx = startOfFrame ? fric(c.vx) : c.vx;
        nvy = startOfFrame ? fric(c.vy) : c.vy;
        if (collision && ((HitEdgeCode[3] && c.vx < 0) || (HitEdgeCode[1] && c.vx > 0))) nvx = -c.vx;
        if (collision && ((HitEdgeCode[2] && c.vy < 0) || (HitEdgeCode[0] && c.vy > 0))) nvy = -c.vy;
        n.vx = nvx;
        n.vy = nvy;
        if (c.st == 2 && startOfFrame && nvx == 0 && nvy == 0) begin
            n.st = 0;
            n.stp = 1'b1;
        end else if (!collision && !startOfFrame) begin
            if (c.st == 1 && releaseBall) begin
                if (c.sx != 0 || c.sy != 0) begin
                    n.vx = c.sx; n.vy = c.sy; n.st = 2;
                end else n.st = 0;
                n.sx = 0; n.sy = 0;
            end else if (c.st != 2) begin
                n.sx = clampi(c.sx + 200 * (int'(chargeRight) - int'(chargeLeft)), 900);
                n.sy = clampi(c.sy + 200 * (int'(chargeDown) - int'(chargeUp)), 900);
                if (c.st == 0 && (chargeUp || chargeDown || chargeLeft || chargeRight)) n.st = 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge resetN)
        if (!resetN) m <= mreset();
        else m <= step(m);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (resetN) begin
            chk("model_x", int'(topLeftX), px_of(m.px));
            chk("model_y", int'(topLeftY), px_of(m.py));
            chk("model_vx", int'(XspeedOUT), m.vx);
            chk("model_vy", int'(YspeedOUT), m.vy);
            chk("model_moving", int'(moving), int'(m.st == 2));
            chk("model_stopped", int'(stoppedPulse), int'(m.stp));
        end

    task automatic apply(input logic [7:0] v, input logic [3:0] code);
        {startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, collision, respawn} = v;
        HitEdgeCode = code;
        @(negedge clk);
        {startOfFrame, chargeUp, chargeDown, chargeLeft, chargeRight, releaseBall, collision, respawn} = '0;
        HitEdgeCode = '0;
        impulseValid = 1'b0;
    endtask

    task automatic chk_spawn(input string tag);
        chk({tag, "_x"}, int'(topLeftX), 100);
        chk({tag, "_y"}, int'(topLeftY), 220);
        chk({tag, "_vx"}, int'(XspeedOUT), 0);
        chk({tag, "_vy"}, int'(YspeedOUT), 0);
        chk({tag, "_moving"}, int'(moving), 0);
    endtask

    initial begin
        logic [7:0] v;
        bit found;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk_spawn("reset");
        chk("reset_stopped", int'(stoppedPulse), 0);

        repeat (3) apply(CR, 4'h0);
        apply(REL, 4'h0);
        chk("shot_vx", int'(XspeedOUT), 600);
        chk("shot_moving", int'(moving), 1);
        apply(SOF, 4'h0);
        chk("frame_x", int'(topLeftX), 109);
        chk("frame_vx", int'(XspeedOUT), 562);

        apply(RSP, 4'h0);
        chk_spawn("respawn");
        chk("respawn_stopped", int'(stoppedPulse), 0);

        repeat (5) apply(CU, 4'h0);
        apply(REL, 4'h0);
        chk("clamp_vy", int'(YspeedOUT), -900);

        apply(RSP, 4'h0);
        repeat (2) apply(CL, 4'h0);
        apply(REL, 4'h0);
        apply(COL, 4'b1000);
        chk("reflect_left", int'(XspeedOUT), 400);
        apply(COL, 4'b1000);
        chk("no_reflect_away", int'(XspeedOUT), 400);
        apply(COL, 4'b0010);
        chk("reflect_right", int'(XspeedOUT), -400);

        apply(RSP, 4'h0);
        apply(CR, 4'h0);
        apply(REL, 4'h0);
        found = 0;
        for (int i = 0; i < 100 && !found; i++)
            if (XspeedOUT == 11'sd3) found = 1;
            else apply(SOF, 4'h0);
        chk("decay_reached_3", int'(found), 1);
        apply(SOF, 4'h0);
        chk("decay_vx2", int'(XspeedOUT), 2);
        chk("decay_stopped_low", int'(stoppedPulse), 0);
        apply(SOF, 4'h0);
        chk("decay_vx0", int'(XspeedOUT), 0);
        chk("stop_pulse", int'(stoppedPulse), 1);
        chk("stop_moving", int'(moving), 0);
        apply(8'h00, 4'h0);
        chk("stop_pulse_one_cycle", int'(stoppedPulse), 0);

        apply(RSP, 4'h0);
        apply(CL, 4'h0);
        apply(REL, 4'h0);
        apply(SOF | COL, 4'b1000);
        chk("reflect_frame_x", int'(topLeftX), 96);
        chk("reflect_frame_vx", int'(XspeedOUT), 200);

        apply(CR, 4'h0);
        apply(REL, 4'h0);
        apply(SOF, 4'h0);
        #2 resetN = 1'b0;
        #1 chk_spawn("async_reset");
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 4000; i++) begin
            v = '0;
            v[7] = $urandom_range(0, 5) == 0;
            for (int b = 3; b <= 6; b++) v[b] = $urandom_range(0, 5) == 0;
            v[2] = $urandom_range(0, 7) == 0;
            v[1] = $urandom_range(0, 11) == 0;
            v[0] = $urandom_range(0, 299) == 0;
            impulseValid = $urandom_range(0, 29) == 0;
            impulseXspeed = 11'($urandom);
            impulseYspeed = 11'($urandom);
            apply(v, 4'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
